// File: rtl/mem_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// FSM encoding, bus widths and address slicing helpers.
package mem_pkg;

  localparam int ADDR_BITS      = 18;
  localparam int DATA_W         = 32;
  localparam int DEF_INDEX_BITS = 6;
  localparam int DEF_TAG_BITS   = ADDR_BITS - DEF_INDEX_BITS - 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_t;

  // Slices for the default geometry; byte-offset bits [1:0] never take part.
  function automatic logic [DEF_INDEX_BITS-1:0] line_index(input logic [ADDR_BITS-1:0] a);
    return a[DEF_INDEX_BITS+1:2];
  endfunction

  function automatic logic [DEF_TAG_BITS-1:0] line_tag(input logic [ADDR_BITS-1:0] a);
    return a[ADDR_BITS-1:DEF_INDEX_BITS+2];
  endfunction

endpackage

// File: rtl/cache_array.sv
// Valid/tag/data storage for one-word cache lines. Lookup is combinational,
// writes land on the clock edge, and only the valid bits are cleared by reset.
module cache_array #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 10,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] i_index,
  input  logic                  i_we,
  input  logic [TAG_BITS-1:0]   i_tag,
  input  logic [DATA_W-1:0]     i_data,
  output logic                  o_valid,
  output logic [TAG_BITS-1:0]   o_tag,
  output logic [DATA_W-1:0]     o_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    r_valid;
  logic [LINES-1:0]    w_line_we;
  logic [TAG_BITS-1:0] r_tag  [LINES];
  logic [DATA_W-1:0]   r_data [LINES];

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line_we
      assign w_line_we[gi] = i_we && (i_index == INDEX_BITS'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else begin
      r_valid <= r_valid | w_line_we;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_index]  <= i_tag;
      r_data[i_index] <= i_data;
    end
  end

  assign o_valid = r_valid[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_data  = r_data[i_index];

endmodule

// File: rtl/mem_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache between the MEM
// stage and sram_ctrl. Read hits are zero-stall; misses and stores freeze the pipe.
module mem_cache_ctrl #(
  parameter int INDEX_BITS = mem_pkg::DEF_INDEX_BITS,
  parameter int ADDR_BITS  = mem_pkg::ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  input  logic                 mem_r_en,
  input  logic                 mem_w_en,
  output logic [31:0]          rdata,
  output logic                 freeze,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [31:0]          sram_wdata,
  output logic                 sram_r_en,
  output logic                 sram_w_en,
  input  logic [31:0]          sram_rdata,
  input  logic                 sram_freeze
);

  import mem_pkg::*;

  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

  state_t                 r_state;
  logic [ADDR_BITS-1:0]   r_sram_addr;
  logic [31:0]            r_sram_wdata;
  logic                   r_sram_r_en;
  logic                   r_sram_w_en;
  logic [31:0]            r_rdata;

  logic [ADDR_BITS-3:0]   w_lookup_word;
  logic [INDEX_BITS-1:0]  w_index;
  logic [TAG_BITS-1:0]    w_tag;
  logic                   w_line_valid;
  logic [TAG_BITS-1:0]    w_line_tag;
  logic [31:0]            w_line_data;
  logic                   w_hit;
  logic                   w_freeze;
  logic                   w_rdata_drive;
  logic [31:0]            w_rdata_src;
  logic                   w_arr_we;
  logic [31:0]            w_arr_data;

  // Outside IDLE the transaction address is the registered copy, so the
  // completion-cycle hit check and line write both use it.
  assign w_lookup_word = (r_state == IDLE) ? addr[ADDR_BITS-1:2] : r_sram_addr[ADDR_BITS-1:2];
  assign w_index       = w_lookup_word[INDEX_BITS-1:0];
  assign w_tag         = w_lookup_word[ADDR_BITS-3:INDEX_BITS];
  assign w_hit         = w_line_valid && (w_line_tag == w_tag);

  cache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_W     (32)
  ) u_cache_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_index (w_index),
    .i_we    (w_arr_we),
    .i_tag   (w_tag),
    .i_data  (w_arr_data),
    .o_valid (w_line_valid),
    .o_tag   (w_line_tag),
    .o_data  (w_line_data)
  );

  always_comb begin
    w_freeze      = 1'b0;
    w_rdata_drive = 1'b0;
    w_rdata_src   = w_line_data;
    w_arr_we      = 1'b0;
    w_arr_data    = sram_rdata;
    case (r_state)
      IDLE: begin
        if (mem_w_en) begin
          w_freeze = 1'b1;
        end else if (mem_r_en) begin
          w_freeze      = !w_hit;
          w_rdata_drive = w_hit;
        end
      end
      RD_MISS: begin
        w_freeze = sram_freeze;
        if (!sram_freeze) begin
          w_rdata_drive = 1'b1;
          w_rdata_src   = sram_rdata;
          w_arr_we      = 1'b1;
        end
      end
      WR_THRU: begin
        w_freeze = sram_freeze;
        // No-write-allocate: only a line already holding this address is refreshed.
        if (!sram_freeze && w_hit) begin
          w_arr_we   = 1'b1;
          w_arr_data = r_sram_wdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_sram_r_en  <= 1'b0;
      r_sram_w_en  <= 1'b0;
      r_rdata      <= '0;
    end else begin
      if (w_rdata_drive) r_rdata <= w_rdata_src;
      case (r_state)
        IDLE: begin
          if (mem_w_en) begin
            r_sram_addr  <= addr;
            r_sram_wdata <= wdata;
            r_sram_w_en  <= 1'b1;
            r_state      <= WR_THRU;
          end else if (mem_r_en && !w_hit) begin
            r_sram_addr  <= addr;
            r_sram_r_en  <= 1'b1;
            r_state      <= RD_MISS;
          end
        end
        RD_MISS: begin
          if (!sram_freeze) begin
            r_sram_r_en <= 1'b0;
            r_state     <= IDLE;
          end
        end
        WR_THRU: begin
          if (!sram_freeze) begin
            r_sram_w_en <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Reset must silence the stall and load data even while a request is still presented.
  assign freeze     = rst_n && w_freeze;
  assign rdata      = (rst_n && w_rdata_drive) ? w_rdata_src : r_rdata;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign sram_r_en  = r_sram_r_en;
  assign sram_w_en  = r_sram_w_en;

endmodule

// File: doc/mem_cache_ctrl.md
Name: mem_cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache. Sits between the MEM pipeline stage and the SRAM controller (sram_ctrl).
- Read hits return data in the same cycle with no stall.
- Read misses and all writes are forwarded to sram_ctrl using its request/freeze handshake. The pipeline is stalled through freeze until sram_ctrl completes.

Parameters:
INDEX_BITS, 6, line index width (2^INDEX_BITS one-word lines)
ADDR_BITS, 18, byte address width shared with sram_ctrl
TAG_BITS, ADDR_BITS-INDEX_BITS-2, stored tag width (derived, not overridable)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
addr  in  18  MEM-stage byte address; bits [1:0] ignored (word access only)
wdata  in  32  MEM-stage store data
mem_r_en  in  1  MEM-stage load request
mem_w_en  in  1  MEM-stage store request
rdata  out  32  load data to MEM stage
freeze  out  1  pipeline stall request
sram_addr  out  18  address to sram_ctrl
sram_wdata  out  32  store data to sram_ctrl
sram_r_en  out  1  read request to sram_ctrl
sram_w_en  out  1  write request to sram_ctrl
sram_rdata  in  32  read data from sram_ctrl
sram_freeze  in  1  sram_ctrl busy; low while a request is asserted means completion this cycle

Behaviour:
- Address split: index = addr[INDEX_BITS+1:2]; tag = addr[17:INDEX_BITS+2].
- Storage per line: valid bit, tag, 32-bit data.
- hit = valid[index] && tag_store[index] == tag.
- Reset (async, rst_n low):
  - state = IDLE; all valid bits cleared (tag/data need no reset).
  - sram_r_en = sram_w_en = 0; sram_addr = 0; sram_wdata = 0; rdata = 0; freeze = 0.
  - Reset mid-transaction abandons the transaction silently. sram_ctrl shares the reset.
- FSM states: IDLE, RD_MISS, WR_THRU.
- IDLE:
  - mem_w_en = 1: freeze = 1 combinationally. Register addr/wdata into sram_addr/sram_wdata. Go to WR_THRU.
  - else mem_r_en = 1 and hit: rdata = line data (combinational), freeze = 0, stay in IDLE.
  - else mem_r_en = 1 and miss: freeze = 1. Register addr into sram_addr. Go to RD_MISS.
  - No request: freeze = 0.
  - mem_r_en and mem_w_en both high is illegal. Write takes priority; the read is not performed.
- RD_MISS:
  - sram_r_en = 1 (registered output).
  - While sram_freeze = 1: freeze = 1, hold.
  - Completion cycle (sram_freeze = 0): rdata = sram_rdata combinationally, freeze = 0. At the clock edge, write line (valid = 1, tag, data = sram_rdata), drop sram_r_en, go to IDLE.
- WR_THRU:
  - sram_w_en = 1 (registered output).
  - While sram_freeze = 1: freeze = 1.
  - Completion cycle: freeze = 0. If the line hits, update its data with the registered wdata; on a miss, make no allocation. Drop sram_w_en, go to IDLE.
- Latency:
  - Read hit: 0 stall cycles.
  - Read miss / write: 1 cycle (IDLE decode) + sram_ctrl latency (3 stall cycles for the 2-bit counter) before completion.
- Request inputs are stable while freeze = 1; the MEM stage holds them. The block registers addr/wdata anyway.
- Back-to-back: the cycle after completion is IDLE, so a new request is decoded immediately. sram enables are low for at least one cycle between transactions, which re-synchronises the sram_ctrl counter.
- Index aliasing: a read miss overwrites any valid line at that index.
- rdata outside hit/completion cycles holds the last driven value. It is don't-care to the MEM stage, but the bench checks it only when valid.

Decomposition:
- Shared package mem_pkg: state encoding (IDLE = 2'd0, RD_MISS = 2'd1, WR_THRU = 2'd2), ADDR_BITS, data width 32, index/tag slice helpers.
- One sub-module: cache_array (valid/tag/data storage; async read, synchronous write, async valid clear on rst_n).
- FSM and handshake stay in mem_cache_ctrl.

Test Plan:
- Reset then load from 0x00040 -> freeze high for 4 cycles, sram_r_en high from cycle 1, rdata = SRAM word at 0x00040 on completion cycle, line 16 valid.
- Repeat load 0x00040 immediately -> freeze = 0, same rdata same cycle, sram_r_en stays 0.
- Store 0xDEADBEEF to 0x00040 (hit) -> sram_w_en asserted, freeze until completion; next load 0x00040 hits with 0xDEADBEEF and no SRAM access.
- Store 0x12345678 to 0x00100 (miss, index 0) -> SRAM written; following load 0x00100 misses and fetches 0x12345678 from SRAM.
- Alias: load 0x00040, then load 0x00140 (same index 16, tag differs) -> second misses; reload 0x00040 misses again.
- Assert rst_n low during RD_MISS stall -> freeze and sram_r_en drop to 0 immediately; after release, load to the same address misses (valid cleared).
